// File: rtl/dual_sram_pkg.sv
// Shared types, init-pattern constants and the FFT ramp generator used by the
// dual-port sample RAM and its init engine.
package dual_sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } init_state_t;

    localparam int INIT_ZERO = 0;
    localparam int INIT_RAMP = 1;

    // Ramp word i = {(2i+1) mod 2^H, (2i) mod 2^H}, H = dwidth/2; imaginary half on top.
    function automatic logic [63:0] ramp_word(input logic [31:0] idx, input int dwidth);
        logic [63:0] two_i;
        logic [63:0] mask;
        int          h;
        h     = dwidth / 2;
        two_i = {31'd0, idx, 1'b0};
        mask  = (64'd1 << h) - 64'd1;
        return (((two_i + 64'd1) & mask) << h) | (two_i & mask);
    endfunction

endpackage

// File: rtl/dual_sram_init_fsm.sv
// Init engine: walks every address once after a start request and supplies the
// fill word for port A's write path; pulses done for one cycle at the end.
module dual_sram_init_fsm
    import dual_sram_pkg::*;
#(
    parameter int DWIDTH    = 32,
    parameter int AWIDTH    = 5,
    parameter int INIT_MODE = 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    output logic              busy_out,
    output logic              done_out,
    output logic              we_out,
    output logic [AWIDTH-1:0] addr_out,
    output logic [DWIDTH-1:0] data_out
);

    localparam logic [AWIDTH-1:0] LAST_ADDR = '1;

    init_state_t       state;
    logic [AWIDTH-1:0] cnt;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of statement order.
            case (state)
                IDLE: begin
                    if (start_in) begin
                        state <= FILL;
                        cnt   <= '0;
                    end
                end
                FILL: begin
                    // Stop at the last word; a second pass is never started.
                    if (cnt == LAST_ADDR) state <= DONE;
                    else                  cnt   <= cnt + AWIDTH'(1);
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_out = (state == FILL);
    assign done_out = (state == DONE);
    assign we_out   = busy_out;
    assign addr_out = cnt;
    assign data_out = (INIT_MODE == INIT_RAMP) ? DWIDTH'(ramp_word(32'(cnt), DWIDTH)) : '0;

endmodule

// File: rtl/dual_sram_ext.sv
// Single-clock true dual-port RAM for the FFT sample path: byte-lane writes,
// read-first cross-port behaviour, A-wins write merge, 1/2-cycle read latency.
module dual_sram_ext
    import dual_sram_pkg::*;
#(
    parameter int DWIDTH     = 32,
    parameter int AWIDTH     = 5,
    parameter int RD_LATENCY = 1,
    parameter int INIT_MODE  = 1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  init_start_in,
    output logic                  init_busy_out,
    output logic                  init_done_out,
    output logic                  collision_out,
    input  logic                  en_a_in,
    input  logic                  we_a_in,
    input  logic [DWIDTH/8-1:0]   be_a_in,
    input  logic [AWIDTH-1:0]     addr_a_in,
    input  logic [DWIDTH-1:0]     d_a_in,
    output logic [DWIDTH-1:0]     d_a_out,
    output logic                  d_a_valid_out,
    input  logic                  en_b_in,
    input  logic                  we_b_in,
    input  logic [DWIDTH/8-1:0]   be_b_in,
    input  logic [AWIDTH-1:0]     addr_b_in,
    input  logic [DWIDTH-1:0]     d_b_in,
    output logic [DWIDTH-1:0]     d_b_out,
    output logic                  d_b_valid_out
);

    localparam int DEPTH = 1 << AWIDTH;
    localparam int NB    = DWIDTH / 8;

    logic [DWIDTH-1:0] mem [DEPTH];

    logic              fill_we;
    logic [AWIDTH-1:0] fill_addr;
    logic [DWIDTH-1:0] fill_data;

    dual_sram_init_fsm #(
        .DWIDTH    (DWIDTH),
        .AWIDTH    (AWIDTH),
        .INIT_MODE (INIT_MODE)
    ) u_init (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .start_in (init_start_in),
        .busy_out (init_busy_out),
        .done_out (init_done_out),
        .we_out   (fill_we),
        .addr_out (fill_addr),
        .data_out (fill_data)
    );

    // User ports are shut off while filling and while reset is held.
    logic              active;
    logic              rd_a, usr_wr_a, wr_a, rd_b, wr_b;
    logic [AWIDTH-1:0] wa_addr;
    logic [DWIDTH-1:0] wa_data;
    logic [NB-1:0]     wa_be;

    always_comb begin
        active   = !rst_in && !init_busy_out;
        rd_a     = active && en_a_in && !we_a_in;
        usr_wr_a = active && en_a_in && we_a_in;
        rd_b     = active && en_b_in && !we_b_in;
        wr_b     = active && en_b_in && we_b_in;
        wr_a     = usr_wr_a || (fill_we && !rst_in);
        wa_addr  = fill_we ? fill_addr : addr_a_in;
        wa_data  = fill_we ? fill_data : d_a_in;
        wa_be    = fill_we ? '1 : be_a_in;
    end

    // NOTE: the array has no reset branch so it maps onto RAM macros; the port A
    // lane update is placed after port B so A wins any lane both ports write.
    always_ff @(posedge clk_in) begin
        for (int k = 0; k < NB; k++) begin
            if (wr_b && be_b_in[k]) mem[addr_b_in][8*k +: 8] <= d_b_in[8*k +: 8];
            if (wr_a && wa_be[k])   mem[wa_addr][8*k +: 8]   <= wa_data[8*k +: 8];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) collision_out <= 1'b0;
        else        collision_out <= usr_wr_a && wr_b && (addr_a_in == addr_b_in)
                                     && |(be_a_in & be_b_in);
    end

    // First read stage; data regs load only on a read so they hold otherwise.
    logic              v1_a, v1_b;
    logic [DWIDTH-1:0] q1_a, q1_b;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            v1_a <= 1'b0;
            v1_b <= 1'b0;
            q1_a <= '0;
            q1_b <= '0;
        end else begin
            v1_a <= rd_a;
            v1_b <= rd_b;
            if (rd_a) q1_a <= mem[addr_a_in];
            if (rd_b) q1_b <= mem[addr_b_in];
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic              v2_a, v2_b;
            logic [DWIDTH-1:0] q2_a, q2_b;

            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    v2_a <= 1'b0;
                    v2_b <= 1'b0;
                    q2_a <= '0;
                    q2_b <= '0;
                end else begin
                    v2_a <= v1_a;
                    v2_b <= v1_b;
                    if (v1_a) q2_a <= q1_a;
                    if (v1_b) q2_b <= q1_b;
                end
            end

            assign d_a_out       = q2_a;
            assign d_a_valid_out = v2_a;
            assign d_b_out       = q2_b;
            assign d_b_valid_out = v2_b;
        end else begin : g_lat1
            assign d_a_out       = q1_a;
            assign d_a_valid_out = v1_a;
            assign d_b_out       = q1_b;
            assign d_b_valid_out = v1_b;
        end
    endgenerate

endmodule

// File: tb/tb_dual_sram_ext.sv
// Directed plus randomized bench for dual_sram_ext against an array-based
// reference memory with read-first and A-over-B lane merge semantics.
module tb_dual_sram_ext;

    localparam int DWIDTH     = 32;
    localparam int AWIDTH     = 5;
    localparam int DEPTH      = 1 << AWIDTH;
    localparam int NB         = DWIDTH / 8;
    localparam int RD_LATENCY = 1;
    localparam int INIT_MODE  = 1;
    localparam int NRAND      = 300;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              init_start_in;
    logic              init_busy_out, init_done_out, collision_out;
    logic              en_a_in, we_a_in, en_b_in, we_b_in;
    logic [NB-1:0]     be_a_in, be_b_in;
    logic [AWIDTH-1:0] addr_a_in, addr_b_in;
    logic [DWIDTH-1:0] d_a_in, d_b_in, d_a_out, d_b_out;
    logic              d_a_valid_out, d_b_valid_out;

    always #5 clk_in = ~clk_in;

    dual_sram_ext #(
        .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .RD_LATENCY(RD_LATENCY), .INIT_MODE(INIT_MODE)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .init_start_in(init_start_in),
        .init_busy_out(init_busy_out), .init_done_out(init_done_out),
        .collision_out(collision_out),
        .en_a_in(en_a_in), .we_a_in(we_a_in), .be_a_in(be_a_in), .addr_a_in(addr_a_in),
        .d_a_in(d_a_in), .d_a_out(d_a_out), .d_a_valid_out(d_a_valid_out),
        .en_b_in(en_b_in), .we_b_in(we_b_in), .be_b_in(be_b_in), .addr_b_in(addr_b_in),
        .d_b_in(d_b_in), .d_b_out(d_b_out), .d_b_valid_out(d_b_valid_out)
    );

    int                n_assert = 0;
    int                n_fail   = 0;
    logic [DWIDTH-1:0] model [DEPTH];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [DWIDTH-1:0] ref_init(input int i);
        logic [63:0] m, re, im;
        if (INIT_MODE == 0) return '0;
        m  = 64'd1 << (DWIDTH / 2);
        re = 64'(2 * i) % m;
        im = 64'(2 * i + 1) % m;
        return DWIDTH'((im << (DWIDTH / 2)) | re);
    endfunction

    function automatic logic [DWIDTH-1:0] merge(input logic [DWIDTH-1:0] old,
                                                input logic [DWIDTH-1:0] d,
                                                input logic [NB-1:0] be);
        for (int k = 0; k < NB; k++)
            if (be[k]) old[8*k +: 8] = d[8*k +: 8];
        return old;
    endfunction

    task automatic idle_inputs();
        en_a_in = 0; we_a_in = 0; be_a_in = '0; addr_a_in = '0; d_a_in = '0;
        en_b_in = 0; we_b_in = 0; be_b_in = '0; addr_b_in = '0; d_b_in = '0;
    endtask

    // One cycle of traffic on both ports, then inputs return to idle.
    task automatic drive(input bit ea, input bit wa, input logic [AWIDTH-1:0] aa,
                         input logic [NB-1:0] ba, input logic [DWIDTH-1:0] da,
                         input bit eb, input bit wb, input logic [AWIDTH-1:0] ab,
                         input logic [NB-1:0] bb, input logic [DWIDTH-1:0] db);
        en_a_in = ea; we_a_in = wa; addr_a_in = aa; be_a_in = ba; d_a_in = da;
        en_b_in = eb; we_b_in = wb; addr_b_in = ab; be_b_in = bb; d_b_in = db;
        tick();
        idle_inputs();
    endtask

    task automatic read_port(input bit pb, input logic [AWIDTH-1:0] a, input string tag);
        if (pb) drive(0, 0, '0, '0, '0, 1, 0, a, '0, '0);
        else    drive(1, 0, a, '0, '0, 0, 0, '0, '0, '0);
        repeat (RD_LATENCY - 1) tick();
        check({tag, "_valid"}, pb ? d_b_valid_out : d_a_valid_out, 1);
        check(tag, pb ? d_b_out : d_a_out, model[a]);
    endtask

    bit                rv_a [NRAND];
    bit                rv_b [NRAND];
    logic [DWIDTH-1:0] rd_a [NRAND];
    logic [DWIDTH-1:0] rd_b [NRAND];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int                busy_cnt, any_done, seen_v;
        bit                saw_valid, col, ev_a, ev_b;
        logic [DWIDTH-1:0] old, seen_d, ex_a, ex_b;

        rst_in = 1; init_start_in = 0; idle_inputs();
        repeat (3) tick();
        check("rst_d_a", d_a_out, 0);
        check("rst_d_b", d_b_out, 0);
        check("rst_valid_a", d_a_valid_out, 0);
        check("rst_valid_b", d_b_valid_out, 0);
        check("rst_busy", init_busy_out, 0);
        check("rst_done", init_done_out, 0);
        check("rst_collision", collision_out, 0);
        rst_in = 0;
        tick();

        // Full fill; a read and a second start are issued mid-fill and must be ignored.
        init_start_in = 1;
        tick();
        init_start_in = 0;
        busy_cnt = 0; saw_valid = 0; any_done = 0;
        while (init_busy_out && busy_cnt < 100) begin
            busy_cnt++;
            if (d_a_valid_out || d_b_valid_out) saw_valid = 1;
            if (init_done_out) any_done++;
            if (busy_cnt == 3)  begin en_a_in = 1; we_a_in = 0; addr_a_in = 4; end
            if (busy_cnt == 4)  en_a_in = 0;
            if (busy_cnt == 10) init_start_in = 1;
            if (busy_cnt == 11) init_start_in = 0;
            tick();
        end
        check("fill_busy_len", busy_cnt, DEPTH);
        check("fill_no_valid", saw_valid, 0);
        check("fill_done_early", any_done, 0);
        check("fill_d_a_held", d_a_out, 0);
        check("fill_done_pulse", init_done_out, 1);
        tick();
        check("fill_done_clear", init_done_out, 0);
        check("fill_busy_clear", init_busy_out, 0);
        for (int i = 0; i < DEPTH; i++) model[i] = ref_init(i);

        read_port(1, 3, "init_rd_b3");
        read_port(0, 0, "init_rd_a0");
        read_port(1, DEPTH - 1, "init_rd_b_last");

        // Partial-lane write, then a write cycle yields no read data on its port.
        drive(1, 1, 5, 4'b0011, 32'hDEADBEEF, 0, 0, '0, '0, '0);
        model[5] = merge(model[5], 32'hDEADBEEF, 4'b0011);
        repeat (RD_LATENCY - 1) tick();
        check("wr_no_valid_a", d_a_valid_out, 0);
        read_port(1, 5, "be_merge_b5");

        // Same-address dual write with overlapping lanes.
        drive(1, 1, 9, 4'b1111, 32'h11111111, 1, 1, 9, 4'b1111, 32'h22222222);
        check("collision_pulse", collision_out, 1);
        tick();
        check("collision_clear", collision_out, 0);
        model[9] = merge(merge(model[9], 32'h22222222, 4'b1111), 32'h11111111, 4'b1111);
        read_port(0, 9, "collision_rd9");

        // Disjoint lanes: both writes land and no collision is flagged.
        drive(1, 1, 12, 4'b0011, 32'h12345678, 1, 1, 12, 4'b1100, 32'h9ABCDEF0);
        check("no_collision", collision_out, 0);
        model[12] = merge(merge(model[12], 32'h9ABCDEF0, 4'b1100), 32'h12345678, 4'b0011);
        read_port(1, 12, "disjoint_rd12");

        // A writes while B reads the same word: B sees the old word.
        old = model[2];
        drive(1, 1, 2, 4'b1111, 32'hAAAA5555, 1, 0, 2, '0, '0);
        model[2] = 32'hAAAA5555;
        repeat (RD_LATENCY - 1) tick();
        check("rf_valid_b", d_b_valid_out, 1);
        check("read_first_b2", d_b_out, old);
        read_port(1, 2, "after_wr_b2");
        read_port(0, 7, "prime_a");

        // Randomized traffic on a small address window to provoke collisions.
        ex_a = d_a_out; ex_b = d_b_out;
        for (int i = 0; i < NRAND + RD_LATENCY; i++) begin
            if (i < NRAND) begin
                en_a_in = 1'($urandom); we_a_in = 1'($urandom); be_a_in = NB'($urandom);
                addr_a_in = AWIDTH'($urandom_range(0, 7)); d_a_in = $urandom;
                en_b_in = 1'($urandom); we_b_in = 1'($urandom); be_b_in = NB'($urandom);
                addr_b_in = AWIDTH'($urandom_range(0, 7)); d_b_in = $urandom;
                rv_a[i] = en_a_in && !we_a_in; rd_a[i] = model[addr_a_in];
                rv_b[i] = en_b_in && !we_b_in; rd_b[i] = model[addr_b_in];
                col = en_a_in && we_a_in && en_b_in && we_b_in && (addr_a_in == addr_b_in)
                      && ((be_a_in & be_b_in) != 0);
                if (en_b_in && we_b_in) model[addr_b_in] = merge(model[addr_b_in], d_b_in, be_b_in);
                if (en_a_in && we_a_in) model[addr_a_in] = merge(model[addr_a_in], d_a_in, be_a_in);
            end else begin
                idle_inputs();
                col = 0;
            end
            tick();
            check("rand_collision", collision_out, col);
            ev_a = 0; ev_b = 0;
            if (i - RD_LATENCY + 1 >= 0 && i - RD_LATENCY + 1 < NRAND) begin
                ev_a = rv_a[i - RD_LATENCY + 1];
                ev_b = rv_b[i - RD_LATENCY + 1];
                if (ev_a) ex_a = rd_a[i - RD_LATENCY + 1];
                if (ev_b) ex_b = rd_b[i - RD_LATENCY + 1];
            end
            check("rand_valid_a", d_a_valid_out, ev_a);
            check("rand_valid_b", d_b_valid_out, ev_b);
            check("rand_d_a", d_a_out, ex_a);
            check("rand_d_b", d_b_out, ex_b);
        end
        idle_inputs();
        tick();

        // Read accepted just before start completes; then reset lands at FILL count 10.
        drive(0, 0, '0, '0, '0, 1, 0, 1, '0, '0);
        init_start_in = 1;
        seen_v = 0; seen_d = '0;
        if (d_b_valid_out) begin seen_v++; seen_d = d_b_out; end
        tick();
        init_start_in = 0;
        if (d_b_valid_out) begin seen_v++; seen_d = d_b_out; end
        check("pre_start_rd_count", seen_v, 1);
        check("pre_start_rd_data", seen_d, model[1]);
        check("refill_busy", init_busy_out, 1);
        busy_cnt = 1;
        while (busy_cnt < 11) begin
            tick();
            busy_cnt++;
        end
        check("refill_busy_at_10", init_busy_out, 1);
        rst_in = 1;
        tick();
        rst_in = 0;
        check("rst_fill_busy", init_busy_out, 0);
        any_done = 0;
        for (int i = 0; i < DEPTH + 8; i++) begin
            if (init_done_out || init_busy_out) any_done++;
            tick();
        end
        check("rst_fill_no_done", any_done, 0);
        for (int i = 0; i < 10; i++) model[i] = ref_init(i);
        for (int i = 0; i < DEPTH; i++) read_port(0, AWIDTH'(i), "partial_fill_rd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dual_sram_ext.md
# dual_sram_ext

Single-clock true dual-port RAM for the FFT sample path: two symmetric read/write ports, byte-lane write enables, selectable read latency, defined cross-port collision behaviour, and a built-in synthesizable init engine. The init engine zero-fills the memory or writes the FFT test ramp on command. The block sits between the FFT read/write sequencers and replaces simulation-only memory preload.

## Interface
- `DWIDTH`, 32, data width; must be even and a multiple of 8.
- `AWIDTH`, 5, address width; `DEPTH = 1 << AWIDTH`.
- `RD_LATENCY`, 1, read latency in cycles; legal values are 1 and 2.
- `INIT_MODE`, 1, init pattern: 0 = zero fill, 1 = ramp.
- `clk_in`  input  1  the single clock.
- `rst_in`  input  1  synchronous, active-high reset.
- `init_start_in`  input  1  one-cycle request to start the init engine.
- `init_busy_out`  output  1  high while the init engine is filling.
- `init_done_out`  output  1  one-cycle pulse when a fill completes.
- `collision_out`  output  1  one-cycle pulse flagging a same-address dual write.
- `en_a_in`, `we_a_in`  input  1  port A enable and write.
- `be_a_in`  input  DWIDTH/8  port A byte-lane write enables.
- `addr_a_in`  input  AWIDTH  port A address.
- `d_a_in`  input  DWIDTH  port A write data.
- `d_a_out`  output  DWIDTH  port A read data.
- `d_a_valid_out`  output  1  port A read-data valid.
- Port B: `en_b_in`, `we_b_in`, `be_b_in`, `addr_b_in`, `d_b_in`, `d_b_out`, `d_b_valid_out`, identical to port A.

## Operation
- Access types:
  - Read: `en & !we`.
  - Write: `en & we`. Only lanes with `be[k]=1` update bits `[8k+7:8k]`.
  - A write cycle produces no read data on the same port.
- Cross-port, same address, same cycle:
  - A writes, B reads (or the reverse): the reader gets the old word (read-first).
  - Both write: the merged result is port B's lanes overlaid by port A's enabled lanes, so A wins per lane. `collision_out` pulses on the next cycle if any lane overlaps.
- Init engine states:
  - IDLE: accepts `init_start_in`.
  - IDLE → FILL on `init_start_in`; address counter cleared to 0.
  - FILL writes word `cnt` each cycle; `cnt` runs 0..DEPTH-1, then FILL → DONE.
  - DONE lasts one cycle, drives `init_done_out`, then returns to IDLE.
- Fill patterns (H = DWIDTH/2):
  - Zero mode: every word is 0.
  - Ramp mode: word i = {(2i+1) mod 2^H, (2i) mod 2^H} (imaginary upper half, real lower half).
- While `init_busy_out=1`:
  - Port enables are ignored.
  - `d_*_out` hold their values and `d_*_valid_out` stay 0.
  - `collision_out` stays 0.
- `init_start_in` during FILL or DONE is ignored.
- Reset:
  - Clears all outputs, the FSM (to IDLE), the counter and the read pipelines.
  - Memory contents are not cleared.
  - Reset mid-FILL leaves the memory partially filled, with no `init_done_out` pulse.

## Timing
- Reset values: `d_a_out = d_b_out = 0`; `d_a_valid_out`, `d_b_valid_out`, `init_busy_out`, `init_done_out`, `collision_out` all 0.
- Read latency:
  - With RD_LATENCY=1, data and valid appear on edge N+1 for a read presented at edge N.
  - With RD_LATENCY=2, they appear on edge N+2.
  - Back-to-back reads give one word per cycle per port.
- `d_*_out` holds its last value when valid is low.
- Write data is visible to a read issued on the next cycle.
- Init timing:
  - `init_busy_out` rises the cycle after `init_start_in` and stays high for exactly DEPTH cycles.
  - `init_done_out` pulses in the cycle after `init_busy_out` falls.
  - Total duration is DEPTH+1 cycles.
  - A read accepted the cycle before `init_start_in` still completes with normal latency.
- Address wrap: the counter stops at DEPTH-1 and does not wrap into a second pass.

## Structure
- Package `dual_sram_pkg`:
  - `init_state_t` enum: IDLE, FILL, DONE.
  - Constants `INIT_ZERO = 0` and `INIT_RAMP = 1`.
  - `ramp_word(i, DWIDTH)` function.
- Sub-module `dual_sram_init_fsm`: owns the FSM, counter and pattern generation. It outputs the write enable, address and data that are muxed into port A's write path.
- The top level keeps the memory array, the lane merge, the collision detect and the read pipelines.

## Test plan
- Reset, then pulse `init_start_in`, with INIT_MODE=1, AWIDTH=5 → `init_busy_out` high for 32 cycles, `init_done_out` one pulse; reading addr 3 returns 0x00070006.
- Write A addr 5 with 0xDEADBEEF and be=4'b0011, then read B addr 5 → 0x0000BEEF (after a zero init), arriving 1 cycle later (RD_LATENCY=1) or 2 cycles later (RD_LATENCY=2).
- Same cycle, A writes 0x11111111 (be=1111) and B writes 0x22222222 (be=1111) to addr 9 → `collision_out` pulses the next cycle; addr 9 then reads 0x11111111.
- A writes 0xAAAA5555 to addr 2 while B reads addr 2 in the same cycle → B returns the old word 0x00050004 (ramp init); the next B read returns 0xAAAA5555.
- Assert `rst_in` at FILL count 10 → FSM returns to IDLE, no `init_done_out`, words 0..9 ramp and words 10..31 unchanged.
- Read issued during FILL → no valid pulse and output held; `init_start_in` pulsed mid-FILL is ignored (busy still exactly 32 cycles).
